// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
//   state_t  : arbiter FSM states
//   gnt_t    : grant / owner encodings shared with the grant output
//   wcmd_t   : write qualifier, write data and byte enables of one command
//   ADDR_W_DEF, DATA_W, BSEL_W : default and fixed field widths
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BSEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_AUX  = 2'd3
  } gnt_t;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [BSEL_W-1:0] bytesel;
  } wcmd_t;

endpackage

// File: rtl/sdram_arb_agecnt.sv
// CPU starvation counter used by the arbiter when SDRAM_ARB_AGE_EN is defined.
//   clk, reset : clock and asynchronous active-high reset
//   cpu_req    : CPU request level
//   cpu_gnt    : CPU is being granted or currently owns the SDRAM
//   aged_c     : CPU has waited at least AGE_LIMIT cycles (decoded from the counter)
module sdram_arb_agecnt
  #(parameter int unsigned AGE_LIMIT = 32)
  (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic cpu_gnt,
    output logic aged_c
  );

  localparam int unsigned CNT_W = $clog2(AGE_LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles, saturating at the limit so it never wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cpu_gnt) begin
      cnt <= '0;
    end else if (cpu_req && (cnt != CNT_W'(AGE_LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign aged_c = (cnt >= CNT_W'(AGE_LIMIT));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter (video refill, CPU, aux DMA) in front of a single SDRAM
// controller. One transaction at a time: IDLE picks a winner and registers its
// command, BUSY holds it until mem_ack, DONE pulses the owner's ack.
// Optional macro SDRAM_ARB_AGE_EN lets a starved CPU beat video for one grant.
//   clk, reset                  : clock, asynchronous active-high reset
//   vid_req/vid_addr/vid_ack    : video read port
//   cpu_* / aux_*               : read/write ports (req, wr, addr, wdata, bytesel, ack)
//   rdata                       : read data captured at mem_ack
//   mem_req/mem_wr/mem_addr/mem_wdata/mem_bytesel : registered command to the controller
//   mem_ack/mem_rdata           : controller completion and read data
//   grant                       : current owner (0 none, 1 video, 2 CPU, 3 aux)
module sdram_port_arbiter
  import sdram_arb_pkg::*;
  #(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned AGE_LIMIT = 32
  )
  (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_bytesel,
    output logic              cpu_ack,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [15:0]       aux_wdata,
    input  logic [1:0]        aux_bytesel,
    output logic              aux_ack,
    output logic [15:0]       rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_bytesel,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [1:0]        grant
  );

  // A zero limit would let the CPU override video on every grant.
  if (AGE_LIMIT == 0) begin : g_age_limit_check
    $error("sdram_port_arbiter: AGE_LIMIT must be at least 1");
  end

  state_t            state_q, state_n;
  gnt_t              grant_q, grant_n;
  logic              mem_req_q, mem_req_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  wcmd_t             cmd_q, cmd_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              vid_ack_q, vid_ack_n;
  logic              cpu_ack_q, cpu_ack_n;
  logic              aux_ack_q, aux_ack_n;
  logic              rr_aux_q, rr_aux_n;   // 0: CPU wins a CPU/aux tie, 1: aux wins
  gnt_t              win_c;
  logic              age_win_c;

`ifdef SDRAM_ARB_AGE_EN
  logic cpu_gnt_c;
  logic aged_c;

  assign cpu_gnt_c = ((state_q == IDLE) && (win_c == GNT_CPU)) || (grant_q == GNT_CPU);

  sdram_arb_agecnt #(.AGE_LIMIT(AGE_LIMIT)) u_agecnt (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (cpu_req),
    .cpu_gnt (cpu_gnt_c),
    .aged_c  (aged_c)
  );

  assign age_win_c = aged_c & cpu_req;
`else
  assign age_win_c = 1'b0;
`endif

  // Winner selection: aged CPU, then video, then CPU/aux by round-robin pointer.
  always_comb begin
    win_c = GNT_NONE;
    if (age_win_c) begin
      win_c = GNT_CPU;
    end else if (vid_req) begin
      win_c = GNT_VID;
    end else if (cpu_req && aux_req) begin
      win_c = rr_aux_q ? GNT_AUX : GNT_CPU;
    end else if (cpu_req) begin
      win_c = GNT_CPU;
    end else if (aux_req) begin
      win_c = GNT_AUX;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    mem_req_n = mem_req_q;
    addr_n    = addr_q;
    cmd_n     = cmd_q;
    rdata_n   = rdata_q;
    vid_ack_n = 1'b0;
    cpu_ack_n = 1'b0;
    aux_ack_n = 1'b0;
    rr_aux_n  = rr_aux_q;

    unique case (state_q)
      IDLE: begin
        if (win_c != GNT_NONE) begin
          state_n   = BUSY;
          grant_n   = win_c;
          mem_req_n = 1'b1;
          unique case (win_c)
            GNT_VID: begin
              addr_n        = vid_addr;
              cmd_n.wr      = 1'b0;
              cmd_n.bytesel = 2'b11;
            end
            GNT_CPU: begin
              addr_n = cpu_addr;
              cmd_n  = '{wr: cpu_wr, wdata: cpu_wdata, bytesel: cpu_bytesel};
            end
            GNT_AUX: begin
              addr_n = aux_addr;
              cmd_n  = '{wr: aux_wr, wdata: aux_wdata, bytesel: aux_bytesel};
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          rdata_n   = mem_rdata;
          unique case (grant_q)
            GNT_VID: vid_ack_n = 1'b1;
            GNT_CPU: begin
              cpu_ack_n = 1'b1;
              rr_aux_n  = ~rr_aux_q;
            end
            GNT_AUX: begin
              aux_ack_n = 1'b1;
              rr_aux_n  = ~rr_aux_q;
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        // Requests are ignored here so a port dropping req on its ack is never re-granted.
        state_n = IDLE;
        grant_n = GNT_NONE;
      end
      default: begin
        state_n   = IDLE;
        grant_n   = GNT_NONE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= '0;
      rdata_q   <= '0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      aux_ack_q <= 1'b0;
      rr_aux_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      mem_req_q <= mem_req_n;
      addr_q    <= addr_n;
      cmd_q     <= cmd_n;
      rdata_q   <= rdata_n;
      vid_ack_q <= vid_ack_n;
      cpu_ack_q <= cpu_ack_n;
      aux_ack_q <= aux_ack_n;
      rr_aux_q  <= rr_aux_n;
    end
  end

  assign grant       = grant_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = cmd_q.wr;
  assign mem_addr    = addr_q;
  assign mem_wdata   = cmd_q.wdata;
  assign mem_bytesel = cmd_q.bytesel;
  assign rdata       = rdata_q;
  assign vid_ack     = vid_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign aux_ack     = aux_ack_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural SDRAM controller and
// an in-order scoreboard of expected transactions.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned AGE_LIMIT = 32;
  localparam logic [1:0]  G_VID     = 2'd1;
  localparam logic [1:0]  G_CPU     = 2'd2;
  localparam logic [1:0]  G_AUX     = 2'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              cpu_req, cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic [1:0]        cpu_bytesel;
  logic              cpu_ack;
  logic              aux_req, aux_wr;
  logic [ADDR_W-1:0] aux_addr;
  logic [15:0]       aux_wdata;
  logic [1:0]        aux_bytesel;
  logic              aux_ack;
  logic [15:0]       rdata;
  logic              mem_req, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_bytesel;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [1:0]        grant;

  typedef struct {
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [15:0]       wdata;
    logic [1:0]        bs;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   lat         = 3;
  bit   sb_bypass   = 1'b0;
  int   stray_cnt   = 0;
  int   ack_total   = 0;
  int   vid_cnt     = 0;
  int   cpu_cnt     = 0;
  int   aux_cnt     = 0;
  bit   hold_vid    = 1'b0;
  bit   hold_cpu    = 1'b0;
  bit   hold_aux    = 1'b0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_ack     (vid_ack),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_bytesel (cpu_bytesel),
    .cpu_ack     (cpu_ack),
    .aux_req     (aux_req),
    .aux_wr      (aux_wr),
    .aux_addr    (aux_addr),
    .aux_wdata   (aux_wdata),
    .aux_bytesel (aux_bytesel),
    .aux_ack     (aux_ack),
    .rdata       (rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_bytesel (mem_bytesel),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .grant       (grant)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Controller read data pattern; address 0x000100 yields 0xBEEF.
  function automatic logic [15:0] model_rd(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [ADDR_W-1:0] a, input logic w,
                      input logic [15:0] d, input logic [1:0] b);
    exp_t e;
    e.gnt = g; e.addr = a; e.wr = w; e.wdata = d; e.bs = b;
    sb_q.push_back(e);
  endtask

  task automatic check_cmd(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q[0];
      check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
      check({tag, "_wr"}, 32'(mem_wr), 32'(e.wr));
      check({tag, "_bytesel"}, 32'(mem_bytesel), 32'(e.bs));
      if (e.wr) check({tag, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
    end
  endtask

  // Behavioural SDRAM controller: acks each command after lat cycles, aborts on reset,
  // and can be asked to emit a stray mem_ack.
  initial begin : ctl
    int  stray_done;
    bit  aborted;
    stray_done = 0;
    mem_ack    = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (stray_done != stray_cnt) begin
        stray_done++;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
      end else if (mem_req && !reset) begin
        if (!sb_bypass) check_cmd("cmd_issue");
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          #1;
          if (!sb_bypass) check_cmd("cmd_hold");
          mem_ack   = 1'b1;
          mem_rdata = model_rd(mem_addr);
          @(posedge clk); #1;
          mem_ack   = 1'b0;
        end
        while (mem_req) @(negedge clk);
      end
    end
  end

  // Ack monitor: pops the scoreboard in order.
  initial begin : mon
    exp_t       e;
    logic [1:0] port;
    forever begin
      @(negedge clk);
      if (vid_ack || cpu_ack || aux_ack) begin
        ack_total++;
        check("ack_onehot", 32'(vid_ack) + 32'(cpu_ack) + 32'(aux_ack), 32'd1);
        port = vid_ack ? G_VID : (cpu_ack ? G_CPU : G_AUX);
        if (!sb_bypass) begin
          check("ack_sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("ack_port", 32'(port), 32'(e.gnt));
            check("ack_grant", 32'(grant), 32'(e.gnt));
            if (!e.wr) check("ack_rdata", 32'(rdata), 32'(model_rd(e.addr)));
          end
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget, input string tag);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (vid_ack) begin seen++; vid_cnt++; if (!hold_vid) vid_req = 1'b0; end
      if (cpu_ack) begin seen++; cpu_cnt++; if (!hold_cpu) cpu_req = 1'b0; end
      if (aux_ack) begin seen++; aux_cnt++; if (!hold_aux) aux_req = 1'b0; end
    end
    check({tag, "_acks_seen"}, 32'(seen), 32'(n));
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    vid_req  = 1'b0;
    cpu_req  = 1'b0;
    aux_req  = 1'b0;
    hold_vid = 1'b0;
    hold_cpu = 1'b0;
    hold_aux = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    reset = 1'b0;
    @(negedge clk);
    vid_cnt = 0;
    cpu_cnt = 0;
    aux_cnt = 0;
  endtask

  initial begin : main
    int n;
    int snap;
    reset = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_bytesel = 2'b00;
    aux_req = 1'b0; aux_wr = 1'b0; aux_addr = '0; aux_wdata = '0; aux_bytesel = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_acks", 32'({vid_ack, cpu_ack, aux_ack}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_bytesel", 32'(mem_bytesel), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single CPU read, 5-cycle controller latency
    lat = 5;
    push(G_CPU, 24'h000100, 1'b0, 16'h0000, 2'b11);
    cpu_addr = 24'h000100; cpu_wr = 1'b0; cpu_bytesel = 2'b11; cpu_req = 1'b1;
    check("r35_mem_req_before", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("r35_mem_req_next", 32'(mem_req), 32'd1);
    check("r35_grant_busy", 32'(grant), 32'(G_CPU));
    cpu_addr = 24'h0ABCDE; cpu_bytesel = 2'b01; cpu_wr = 1'b1;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (mem_ack) break;
    end
    check("r35_mem_ack_seen", 32'(mem_ack), 32'd1);
    @(negedge clk);
    check("r35_cpu_ack", 32'(cpu_ack), 32'd1);
    check("r35_rdata", 32'(rdata), 32'h0000BEEF);
    check("r35_grant_done", 32'(grant), 32'(G_CPU));
    cpu_req = 1'b0; cpu_wr = 1'b0;
    @(negedge clk);
    check("r35_cpu_ack_drop", 32'(cpu_ack), 32'd0);
    check("r35_grant_idle", 32'(grant), 32'd0);
    check("r35_mem_req_drop", 32'(mem_req), 32'd0);

    // Stray mem_ack while idle
    snap = ack_total;
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("r40_no_ack", 32'(ack_total), 32'(snap));
    check("r40_rdata_kept", 32'(rdata), 32'h0000BEEF);
    check("r40_grant", 32'(grant), 32'd0);

    // All three ports at once
    apply_reset();
    lat = 2;
    push(G_VID, 24'h001000, 1'b0, 16'h0000, 2'b11);
    push(G_CPU, 24'h002000, 1'b1, 16'h1357, 2'b01);
    push(G_AUX, 24'h003000, 1'b0, 16'h0000, 2'b11);
    vid_addr = 24'h001000;
    cpu_addr = 24'h002000; cpu_wr = 1'b1; cpu_wdata = 16'h1357; cpu_bytesel = 2'b01;
    aux_addr = 24'h003000; aux_wr = 1'b0; aux_bytesel = 2'b11;
    vid_req = 1'b1; cpu_req = 1'b1; aux_req = 1'b1;
    wait_acks(3, 100, "r36");
    repeat (5) @(negedge clk);
    check("r36_vid_once", 32'(vid_cnt), 32'd1);
    check("r36_cpu_once", 32'(cpu_cnt), 32'd1);
    check("r36_aux_once", 32'(aux_cnt), 32'd1);
    check("r36_sb_drained", 32'(sb_q.size()), 32'd0);

    // CPU and aux held: strict alternation
    vid_cnt = 0; cpu_cnt = 0; aux_cnt = 0;
    cpu_addr = 24'h004000; cpu_wr = 1'b0; cpu_bytesel = 2'b11;
    aux_addr = 24'h005000; aux_wr = 1'b1; aux_wdata = 16'hA55A; aux_bytesel = 2'b10;
    for (int i = 0; i < 3; i++) begin
      push(G_CPU, 24'h004000, 1'b0, 16'h0000, 2'b11);
      push(G_AUX, 24'h005000, 1'b1, 16'hA55A, 2'b10);
    end
    hold_cpu = 1'b1; hold_aux = 1'b1;
    cpu_req = 1'b1; aux_req = 1'b1;
    wait_acks(6, 150, "r37");
    cpu_req = 1'b0; aux_req = 1'b0;
    hold_cpu = 1'b0; hold_aux = 1'b0;
    repeat (4) @(negedge clk);
    check("r37_cpu_cnt", 32'(cpu_cnt), 32'd3);
    check("r37_aux_cnt", 32'(aux_cnt), 32'd3);
    check("r37_grant_idle", 32'(grant), 32'd0);
    aux_wr = 1'b0;

    // Reset during BUSY abandons the transaction
    lat = 8;
    push(G_CPU, 24'h000200, 1'b0, 16'h0000, 2'b11);
    cpu_addr = 24'h000200; cpu_wr = 1'b0; cpu_bytesel = 2'b11; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    check("r38_grant_busy", 32'(grant), 32'(G_CPU));
    check("r38_mem_req_busy", 32'(mem_req), 32'd1);
    snap = ack_total;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("r38_mem_req_rst", 32'(mem_req), 32'd0);
    check("r38_grant_rst", 32'(grant), 32'd0);
    sb_q.delete();
    reset = 1'b0;
    stray_cnt++;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (mem_ack) break;
    end
    check("r38_mem_ack_seen", 32'(mem_ack), 32'd1);
    repeat (3) @(negedge clk);
    check("r38_no_ack", 32'(ack_total), 32'(snap));
    check("r38_mem_req", 32'(mem_req), 32'd0);
    check("r38_grant", 32'(grant), 32'd0);
    check("r38_rdata", 32'(rdata), 32'd0);

    // Video held against a waiting CPU
    apply_reset();
    lat = 1;
    sb_bypass = 1'b1;
    vid_addr = 24'h006000;
    cpu_addr = 24'h007000; cpu_wr = 1'b0; cpu_bytesel = 2'b11;
    hold_vid = 1'b1; hold_cpu = 1'b1;
    vid_req = 1'b1; cpu_req = 1'b1;
    wait_acks(12, 200, "r39_mix");
`ifdef SDRAM_ARB_AGE_EN
    check("r39_cpu_aged", 32'(cpu_cnt), 32'd1);
    check("r39_vid_cnt", 32'(vid_cnt), 32'd11);
`else
    check("r39_cpu_starved", 32'(cpu_cnt), 32'd0);
    check("r39_vid_cnt", 32'(vid_cnt), 32'd12);
`endif
    snap = cpu_cnt;
    hold_vid = 1'b0; vid_req = 1'b0;
    wait_acks(1, 40, "r39_cpu_after");
    check("r39_cpu_granted", 32'(cpu_cnt), 32'(snap + 1));
    hold_cpu = 1'b0; cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    sb_bypass = 1'b0;
    check("r39_grant_idle", 32'(grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
